rs_bank_controller: RTL
=======================

// Module: rs_bank_controller
// PURPOSE
//   Shares one bank of WIDTH RS flip-flops between two requesters.
//   - Arbitrates the requesters round-robin.
//   - Turns each granted command into timed R/S pulses: drive phase, then a hold gap.
//   - Guarantees R and S are never both high on any bit.
//   - Sits between requester logic and the RS_flipflop bank; reads the bank's Q back for toggle.
// PARAMETERS
//   WIDTH      4  number of RS flip-flops in the bank (>=1)
//   PULSE_CYC  2  cycles R/S stay asserted per command (>=1)
//   GAP_CYC    1  hold cycles (R=S=0) after each pulse (>=1)
// PORTS
//   Clk    in   1      single system clock, rising edge
//   Reset  in   1      asynchronous, active-high reset
//   req0   in   1      requester 0 request; held until gnt0
//   cmd0   in   2      00 hold, 01 set, 10 reset, 11 toggle
//   mask0  in   WIDTH  bits affected by cmd0
//   gnt0   out  1      one-cycle grant to requester 0
//   req1   in   1      requester 1 request
//   cmd1   in   2      as cmd0
//   mask1  in   WIDTH  as mask0
//   gnt1   out  1      one-cycle grant to requester 1
//   Q      in   WIDTH  flip-flop bank outputs (feedback)
//   R      out  WIDTH  reset drive to bank, registered
//   S      out  WIDTH  set drive to bank, registered
//   busy   out  1      high whenever state != IDLE
//   done   out  1      one-cycle pulse in the last GAP cycle
// BEHAVIOUR
//   Reset (async): R=S=0, gnt0=gnt1=busy=done=0, state=IDLE, rr_ptr=0 (req0 preferred).
//   FSM states:
//     IDLE  -> DRIVE on any req; latches the winner's cmd/mask at that edge.
//     DRIVE -> GAP after PULSE_CYC cycles.
//     GAP   -> IDLE after GAP_CYC cycles.
//   Arbitration: evaluated only in IDLE.
//     - Single request wins.
//     - Both requesting: rr_ptr side wins; rr_ptr flips to the loser after every grant.
//   Latency: IDLE edge sees req -> next cycle is the first DRIVE cycle.
//     - gnt of the winner high for exactly that cycle.
//     - R/S registered outputs valid from that same cycle.
//   Drive values, fixed for the whole DRIVE phase:
//     - set:    S=mask, R=0
//     - reset:  R=mask, S=0
//     - hold:   R=S=0 (slot still consumed, done still pulses)
//     - toggle: Q sampled at the grant edge; S=mask&~Qs, R=mask&Qs
//   GAP: R=S=0; done=1 in the final GAP cycle; IDLE re-arbitrates on the following edge.
//   Minimum command period = 1+PULSE_CYC+GAP_CYC cycles (IDLE cycle included).
//   Requester handshake:
//     - Must drop req in the cycle after gnt; a req still high then is treated as a new request.
//     - cmd/mask may change after gnt.
//   Req arriving during DRIVE/GAP: waits; never dropped, never pre-empts.
//   Invariant: (R & S)==0 every cycle, including reset exit and toggle.
//   Phase counter: $clog2(max(PULSE_CYC,GAP_CYC)+1) bits; reloads on each state entry.
//   Reset mid-DRIVE/GAP: R/S drop immediately; command abandoned, no done, no gnt replay.
// TESTING (WIDTH=4, PULSE_CYC=2, GAP_CYC=1)
//   1 Assert Reset with arbitrary inputs -> R=S=0000, gnt0=gnt1=busy=done=0 immediately.
//   2 req0 cmd=01 mask=0101 from Q=0000:
//     - gnt0 1 cycle; S=0101, R=0000 for 2 cycles; then R=S=0 and done for 1 cycle.
//     - Q=0101; busy high 3 cycles.
//   3 After reset, req0 (01,1111) and req1 (10,0011) on the same edge:
//     - req0 served first, req1 starts the cycle after done+IDLE.
//     - Q goes 1111 then 1100; R&S==0 throughout.
//   4 Q=1100, req1 cmd=11 mask=1111 -> S=0011, R=1100 for 2 cycles; Q=0011 afterwards.
//   5 Reset pulsed in 2nd DRIVE cycle of a set -> R=S=0 same cycle, no done.
//     - After release, a simultaneous req0/req1 grants req0.
//   6 req0 and req1 held high, re-asserted after each gnt -> grants alternate 0,1,0,1.
//     - Grant spacing 4 cycles; no cycle with gnt0 and gnt1 both high.

Source files
------------

// File: rtl/rs_bank_controller.sv
// Round-robin controller sharing one RS flip-flop bank between two requesters.
// Each granted command becomes a PULSE_CYC drive phase followed by a GAP_CYC hold gap.
module rs_bank_controller #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req0,
    input  logic [1:0]       cmd0,
    input  logic [WIDTH-1:0] mask0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [1:0]       cmd1,
    input  logic [WIDTH-1:0] mask1,
    output logic             gnt1,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] S,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MaxCyc = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CntW   = (MaxCyc < 1) ? 1 : $clog2(MaxCyc + 1);

    typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  r_q, r_d, s_q, s_d;
    logic              rr_q, rr_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              win1;
    logic [1:0]        sel_cmd;
    logic [WIDTH-1:0]  sel_mask;

    // rr_q = 1 means requester 1 is preferred when both request
    assign win1     = req1 & (~req0 | rr_q);
    assign sel_cmd  = win1 ? cmd1 : cmd0;
    assign sel_mask = win1 ? mask1 : mask0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        s_d     = s_q;
        rr_d    = rr_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    state_d = StDrive;
                    cnt_d   = CntW'(PULSE_CYC - 1);
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    rr_d    = ~win1;
                    unique case (sel_cmd)
                        2'b01: begin
                            s_d = sel_mask;
                            r_d = '0;
                        end
                        2'b10: begin
                            s_d = '0;
                            r_d = sel_mask;
                        end
                        // Toggle splits the mask on the sampled Q, so R and S stay disjoint
                        2'b11: begin
                            s_d = sel_mask & ~Q;
                            r_d = sel_mask & Q;
                        end
                        default: begin
                            s_d = '0;
                            r_d = '0;
                        end
                    endcase
                end
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = CntW'(GAP_CYC - 1);
                    r_d     = '0;
                    s_d     = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                r_d     = '0;
                s_d     = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            s_q     <= '0;
            rr_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            s_q     <= s_d;
            rr_q    <= rr_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    assign R    = r_q;
    assign S    = s_q;
    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign busy = (state_q != StIdle);
    assign done = (state_q == StGap) && (cnt_q == '0);

endmodule
